// File: rtl/acq_sequencer_if.sv
// Control/status bundle between the acquisition sequencer and its host/trigger/buffer logic.
// The sequencer uses the slave side and the host uses the master side.
interface acq_sequencer_if #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic                  arm;
    logic                  abort;
    logic                  single_shot;
    logic                  auto_mode;
    logic [DEPTH_LOG2-1:0] pretrig_len;
    logic [DEPTH_LOG2-1:0] posttrig_len;
    logic [CNT_WIDTH-1:0]  holdoff_len;
    logic [CNT_WIDTH-1:0]  timeout_len;
    logic                  sample_valid;
    logic                  trig_in;
    logic                  force_trig;
    logic                  done_ack;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2-1:0] trig_addr;
    logic [DEPTH_LOG2-1:0] start_addr;
    logic                  done;
    logic                  busy;
    logic                  timed_out;
    logic [2:0]            state;
    logic [15:0]           acq_count;

    modport master (
        output arm, abort, single_shot, auto_mode, pretrig_len, posttrig_len, holdoff_len,
               timeout_len, sample_valid, trig_in, force_trig, done_ack,
        input  wr_en, wr_addr, trig_addr, start_addr, done, busy, timed_out, state, acq_count
    );

    modport slave (
        input  arm, abort, single_shot, auto_mode, pretrig_len, posttrig_len, holdoff_len,
               timeout_len, sample_valid, trig_in, force_trig, done_ack,
        output wr_en, wr_addr, trig_addr, start_addr, done, busy, timed_out, state, acq_count
    );
endinterface

// File: rtl/acq_sequencer.sv
// Capture sequencer for a circular sample buffer: arm, pre-trigger fill, trigger wait,
// post-trigger count, done handshake and holdoff, with single-shot or continuous re-arm.
module acq_sequencer #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input logic            clk,
    input logic            rst,
    acq_sequencer_if.slave bus
);
    localparam int unsigned PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] Full    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] PostOne = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPretrig  = 3'd1,
        StWaitTrig = 3'd2,
        StPosttrig = 3'd3,
        StDone     = 3'd4,
        StHoldoff  = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
    logic [DEPTH_LOG2-1:0] trig_addr_q, trig_addr_d;
    logic [DEPTH_LOG2-1:0] start_addr_q, start_addr_d;
    logic                  done_q, done_d;
    logic                  timed_out_q, timed_out_d;
    logic [15:0]           acq_count_q, acq_count_d;
    logic [DEPTH_LOG2-1:0] pre_q, pre_d;
    logic [PW-1:0]         post_q, post_d;
    logic [DEPTH_LOG2-1:0] pre_cnt_q, pre_cnt_d;
    logic [PW-1:0]         post_cnt_q, post_cnt_d;
    logic [CNT_WIDTH-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CNT_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;

    logic                  wr_en;
    logic                  trig_hw, trig_auto, do_arm, do_finish;
    logic [PW-1:0]         room, post_lim, post_new;

    // Post length is clipped so pre + post never exceeds the buffer.
    assign room     = Full - {1'b0, bus.pretrig_len};
    assign post_lim = ({1'b0, bus.posttrig_len} < room) ? {1'b0, bus.posttrig_len} : room;
    assign post_new = (post_lim == '0) ? PostOne : post_lim;

    assign trig_hw   = bus.trig_in & bus.sample_valid;
    assign trig_auto = bus.auto_mode && (bus.timeout_len != '0) &&
                       (tmo_cnt_q == bus.timeout_len - 1'b1);

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        done_d       = done_q;
        timed_out_d  = timed_out_q;
        acq_count_d  = acq_count_q;
        pre_d        = pre_q;
        post_d       = post_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        tmo_cnt_d    = (state_q == StWaitTrig) ? tmo_cnt_q + 1'b1 : '0;
        hold_cnt_d   = (state_q == StHoldoff) ? hold_cnt_q + 1'b1 : '0;
        do_arm       = 1'b0;
        do_finish    = 1'b0;
        wr_en        = bus.sample_valid &&
                       (state_q inside {StPretrig, StWaitTrig, StPosttrig});

        if (wr_en) wr_addr_d = wr_addr_q + 1'b1;

        if (bus.abort) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: do_arm = bus.arm;
                StPretrig: begin
                    if (bus.sample_valid) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                        if (pre_cnt_d == pre_q) state_d = StWaitTrig;
                    end
                end
                StWaitTrig: begin
                    if (trig_hw || bus.force_trig || trig_auto) begin
                        trig_addr_d = wr_addr_q;
                        post_cnt_d  = {{DEPTH_LOG2{1'b0}}, bus.sample_valid};
                        timed_out_d = trig_auto & ~trig_hw & ~bus.force_trig;
                        if (post_q == PostOne && bus.sample_valid) do_finish = 1'b1;
                        else state_d = StPosttrig;
                    end
                end
                StPosttrig: begin
                    if (bus.sample_valid) begin
                        post_cnt_d = post_cnt_q + 1'b1;
                        if (post_cnt_d == post_q) do_finish = 1'b1;
                    end
                end
                StDone: begin
                    if (bus.done_ack) begin
                        state_d = StHoldoff;
                        done_d  = 1'b0;
                    end
                end
                StHoldoff: begin
                    if (bus.holdoff_len == '0 || hold_cnt_q == bus.holdoff_len - 1'b1) begin
                        if (bus.single_shot) state_d = StIdle;
                        else do_arm = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (do_arm) begin
                pre_d       = bus.pretrig_len;
                post_d      = post_new;
                pre_cnt_d   = '0;
                wr_addr_d   = '0;
                timed_out_d = 1'b0;
                state_d     = (bus.pretrig_len != '0) ? StPretrig : StWaitTrig;
            end

            if (do_finish) begin
                state_d      = StDone;
                start_addr_d = trig_addr_d - pre_q;
                done_d       = 1'b1;
                acq_count_d  = acq_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            wr_addr_q    <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            acq_count_q  <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            done_q       <= done_d;
            timed_out_q  <= timed_out_d;
            acq_count_q  <= acq_count_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.trig_addr  = trig_addr_q;
    assign bus.start_addr = start_addr_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.timed_out  = timed_out_q;
    assign bus.state      = state_q;
    assign bus.acq_count  = acq_count_q;
endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with a 16-entry buffer: table of capture scenarios
// plus hand-written sequences for auto-trigger, abort, continuous re-arm and reset.
module tb_acq_sequencer;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_count = 0;
    int   dk;

    acq_sequencer_if #(.DEPTH_LOG2(D), .CNT_WIDTH(CW)) bus ();
    acq_sequencer #(.DEPTH_LOG2(D), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int pre;
        int post;
        int trig_at;
        int exp_trig;
        int exp_start;
        int exp_done_k;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_capture(input int pre, input int post);
        bus.pretrig_len  = D'(pre);
        bus.posttrig_len = D'(post);
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
    endtask

    // Sample k (counted from arm) is presented in the k-th cycle; returns k of the completing one.
    task automatic run_to_done(input int trig_at, output int done_k);
        done_k = -1;
        for (int k = 0; k < 64; k++) begin
            bus.trig_in = (k == trig_at);
            step();
            if (bus.done) begin
                done_k = k;
                break;
            end
        end
        bus.trig_in = 1'b0;
    endtask

    task automatic ack_done();
        bus.done_ack = 1'b1;
        step();
        bus.done_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{pre: 4,  post: 8, trig_at: 10, exp_trig: 10, exp_start: 6,  exp_done_k: 17};
        vecs[1] = '{pre: 4,  post: 8, trig_at: 18, exp_trig: 2,  exp_start: 14, exp_done_k: 25};
        vecs[2] = '{pre: 0,  post: 3, trig_at: 5,  exp_trig: 5,  exp_start: 5,  exp_done_k: 7};
        vecs[3] = '{pre: 15, post: 5, trig_at: 20, exp_trig: 4,  exp_start: 5,  exp_done_k: 20};
        vecs[4] = '{pre: 2,  post: 0, trig_at: 2,  exp_trig: 2,  exp_start: 0,  exp_done_k: 2};
        vecs[5] = '{pre: 12, post: 9, trig_at: 12, exp_trig: 12, exp_start: 0,  exp_done_k: 15};

        rst = 1'b0;
        bus.arm = 1'b0;          bus.abort = 1'b0;       bus.single_shot = 1'b1;
        bus.auto_mode = 1'b0;    bus.pretrig_len = '0;   bus.posttrig_len = '0;
        bus.holdoff_len = '0;    bus.timeout_len = '0;   bus.sample_valid = 1'b1;
        bus.trig_in = 1'b0;      bus.force_trig = 1'b0;  bus.done_ack = 1'b0;
        step();
        step();
        check("rst state", int'(bus.state), 0);
        check("rst wr_addr", int'(bus.wr_addr), 0);
        check("rst trig_addr", int'(bus.trig_addr), 0);
        check("rst start_addr", int'(bus.start_addr), 0);
        check("rst done", int'(bus.done), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst timed_out", int'(bus.timed_out), 0);
        check("rst acq_count", int'(bus.acq_count), 0);
        check("rst wr_en", int'(bus.wr_en), 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            arm_capture(vecs[i].pre, vecs[i].post);
            run_to_done(vecs[i].trig_at, dk);
            exp_count++;
            check($sformatf("v%0d done_k", i), dk, vecs[i].exp_done_k);
            check($sformatf("v%0d trig_addr", i), int'(bus.trig_addr), vecs[i].exp_trig);
            check($sformatf("v%0d start_addr", i), int'(bus.start_addr), vecs[i].exp_start);
            check($sformatf("v%0d acq_count", i), int'(bus.acq_count), exp_count);
            check($sformatf("v%0d state done", i), int'(bus.state), 4);
            check($sformatf("v%0d wr_en in done", i), int'(bus.wr_en), 0);
            check($sformatf("v%0d timed_out", i), int'(bus.timed_out), 0);
            ack_done();
            check($sformatf("v%0d state holdoff", i), int'(bus.state), 5);
            check($sformatf("v%0d done cleared", i), int'(bus.done), 0);
            step();
            check($sformatf("v%0d back idle", i), int'(bus.state), 0);
            check($sformatf("v%0d busy idle", i), int'(bus.busy), 0);
        end

        // Auto-trigger on the 5th WAIT_TRIG cycle with no samples arriving.
        bus.sample_valid = 1'b0;
        bus.auto_mode = 1'b1;
        bus.timeout_len = 5;
        arm_capture(0, 2);
        for (int c = 0; c < 4; c++) step();
        check("auto still waiting", int'(bus.state), 2);
        step();
        check("auto posttrig", int'(bus.state), 3);
        check("auto timed_out", int'(bus.timed_out), 1);
        check("auto trig_addr", int'(bus.trig_addr), 0);
        bus.sample_valid = 1'b1;
        step();
        step();
        exp_count++;
        check("auto done", int'(bus.done), 1);
        check("auto acq_count", int'(bus.acq_count), exp_count);
        ack_done();
        step();
        bus.auto_mode = 1'b0;
        bus.timeout_len = 0;

        // trig_in during PRETRIG is ignored; abort mid-POSTTRIG.
        arm_capture(4, 8);
        check("arm clears timed_out", int'(bus.timed_out), 0);
        bus.trig_in = 1'b1;
        for (int k = 0; k < 4; k++) step();
        bus.trig_in = 1'b0;
        step();
        step();
        check("pretrig trig ignored", int'(bus.state), 2);
        check("wr_en in wait", int'(bus.wr_en), 1);
        bus.trig_in = 1'b1;
        step();
        bus.trig_in = 1'b0;
        check("abort seq posttrig", int'(bus.state), 3);
        check("abort seq trig_addr", int'(bus.trig_addr), 6);
        step();
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort state", int'(bus.state), 0);
        check("abort done", int'(bus.done), 0);
        check("abort busy", int'(bus.busy), 0);
        check("abort acq_count", int'(bus.acq_count), exp_count);

        // Continuous mode: 3 holdoff cycles then automatic re-arm.
        bus.single_shot = 1'b0;
        bus.holdoff_len = 3;
        arm_capture(4, 8);
        run_to_done(10, dk);
        exp_count++;
        check("cont1 done_k", dk, 17);
        ack_done();
        check("cont holdoff 1", int'(bus.state), 5);
        step();
        check("cont holdoff 2", int'(bus.state), 5);
        step();
        check("cont holdoff 3", int'(bus.state), 5);
        step();
        check("cont rearm state", int'(bus.state), 1);
        check("cont rearm wr_addr", int'(bus.wr_addr), 0);
        run_to_done(10, dk);
        exp_count++;
        check("cont2 done_k", dk, 17);
        check("cont2 acq_count", int'(bus.acq_count), exp_count);
        bus.single_shot = 1'b1;
        ack_done();
        step();
        step();
        step();
        check("cont single idle", int'(bus.state), 0);
        bus.holdoff_len = 0;

        // pre=0 post=0: trig_in, force_trig and auto coincide -> one non-auto trigger.
        bus.auto_mode = 1'b1;
        bus.timeout_len = 3;
        arm_capture(0, 0);
        step();
        step();
        bus.trig_in = 1'b1;
        bus.force_trig = 1'b1;
        step();
        bus.trig_in = 1'b0;
        bus.force_trig = 1'b0;
        exp_count++;
        check("coinc state", int'(bus.state), 4);
        check("coinc done", int'(bus.done), 1);
        check("coinc timed_out", int'(bus.timed_out), 0);
        check("coinc trig_addr", int'(bus.trig_addr), 2);
        check("coinc start_addr", int'(bus.start_addr), 2);
        check("coinc acq_count", int'(bus.acq_count), exp_count);
        ack_done();
        step();
        bus.auto_mode = 1'b0;
        bus.timeout_len = 0;

        // Reset mid-capture.
        arm_capture(4, 8);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst state", int'(bus.state), 0);
        check("midrst wr_addr", int'(bus.wr_addr), 0);
        check("midrst acq_count", int'(bus.acq_count), 0);
        check("midrst busy", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
